board_mem_responder: RTL and testbench

// Avalon-MM slave model of board memory: the responder end of the move-generator accelerators' SDRAM-facing master.

---
 rtl/board_mem_responder_pkg.sv | 19 +
 rtl/board_mem_responder_rd_pipe.sv | 35 +++
 rtl/board_mem_responder.sv | 105 ++++++++++
 tb/tb_board_mem_responder.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/board_mem_responder_pkg.sv
// Shared board-memory types and constants for the move-generator accelerators.
package chess_pkg;

    typedef logic signed [7:0] piece_t;

    localparam piece_t EMPTY_PC          = 8'sd0;
    localparam int     SQUARES_PER_BOARD = 64;
    localparam int     BYTES_PER_SQUARE  = 4;
    localparam int     BOARD_STRIDE      = SQUARES_PER_BOARD * BYTES_PER_SQUARE;

    localparam logic [31:0] OOR_DATA = 32'hFFFF_FFFF;

    typedef enum logic {CLEAR, READY} bmem_state_t;

    function automatic logic [31:0] sext_piece(input piece_t p);
        return {{24{p[7]}}, p};
    endfunction

endpackage

// File: rtl/board_mem_responder_rd_pipe.sv
// Read-response shift pipe: fixed latency, data held on the last stage between pulses.
module board_mem_rd_pipe #(
    parameter int RD_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    output logic        out_valid,
    output logic [31:0] out_data
);

    logic [RD_LATENCY-1:0] valid_q;
    logic [31:0]           data_q [RD_LATENCY];

    // NOTE: sequential state uses non-blocking assignments so every stage samples its predecessor's pre-edge value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < RD_LATENCY; i++) data_q[i] <= '0;
        end else begin
            valid_q[0] <= in_valid;
            if (in_valid) data_q[0] <= in_data;
            // Data only advances alongside a valid token, so the output holds its last value.
            for (int i = 1; i < RD_LATENCY; i++) begin
                valid_q[i] <= valid_q[i-1];
                if (valid_q[i-1]) data_q[i] <= data_q[i-1];
            end
        end
    end

    assign out_valid = valid_q[RD_LATENCY-1];
    assign out_data  = data_q[RD_LATENCY-1];

endmodule

// File: rtl/board_mem_responder.sv
// Avalon-MM slave board store: CLEAR sweep after reset, then wait-stated reads/writes.
module board_mem_responder
    import chess_pkg::*;
#(
    parameter int NUM_BOARDS  = 8,
    parameter int WAIT_STATES = 1,
    parameter int RD_LATENCY  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        slave_waitrequest,
    input  logic [31:0] slave_address,
    input  logic        slave_read,
    output logic [31:0] slave_readdata,
    output logic        slave_readdatavalid,
    input  logic        slave_write,
    input  logic [31:0] slave_writedata,
    output logic        err,
    input  logic        err_clr
);

    localparam int WORDS = NUM_BOARDS * (BOARD_STRIDE / BYTES_PER_SQUARE);
    localparam int IDX_W = $clog2(WORDS);

    bmem_state_t      state_q, state_d;
    logic [IDX_W-1:0] clr_idx_q, clr_idx_d;
    logic [3:0]       stall_cnt_q, stall_cnt_d;
    logic             err_q, err_d;

    piece_t mem [WORDS];

    logic [31:0] idx;
    logic        cmd, accept, in_range, wr_acc, rd_acc;
    logic [31:0] rd_word;
    logic        unused_wdata;

    assign unused_wdata = ^slave_writedata[31:8];

    assign idx      = slave_address >> $clog2(BYTES_PER_SQUARE);
    assign in_range = idx < 32'(WORDS);
    assign cmd      = slave_read | slave_write;

    assign slave_waitrequest = (state_q == CLEAR) ? 1'b1
                             : (!cmd ? 1'b0 : (stall_cnt_q != 4'(WAIT_STATES)));

    assign accept = (state_q == READY) && cmd && !slave_waitrequest;
    assign wr_acc = accept && slave_write;
    assign rd_acc = accept && slave_read && !slave_write;
    assign rd_word = in_range ? sext_piece(mem[idx[IDX_W-1:0]]) : OOR_DATA;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        clr_idx_d   = clr_idx_q;
        stall_cnt_d = 4'd0;
        err_d       = err_q;

        case (state_q)
            CLEAR: begin
                clr_idx_d = clr_idx_q + 1'b1;
                if (clr_idx_q == IDX_W'(WORDS - 1)) state_d = READY;
            end
            READY: begin
                if (cmd && !accept && stall_cnt_q != 4'hF) stall_cnt_d = stall_cnt_q + 4'd1;
                else if (cmd && !accept)                   stall_cnt_d = stall_cnt_q;
            end
            default: state_d = CLEAR;
        endcase

        if (err_clr) err_d = 1'b0;
        if (accept && (!in_range || (slave_read && slave_write))) err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= CLEAR;
            clr_idx_q   <= '0;
            stall_cnt_q <= 4'd0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_idx_q   <= clr_idx_d;
            stall_cnt_q <= stall_cnt_d;
            err_q       <= err_d;
        end
    end

    // NOTE: the array has no reset; the CLEAR sweep is what initialises its contents.
    always_ff @(posedge clk) begin
        if (state_q == CLEAR)         mem[clr_idx_q]         <= EMPTY_PC;
        else if (wr_acc && in_range)  mem[idx[IDX_W-1:0]]    <= piece_t'(slave_writedata[7:0]);
    end

    board_mem_rd_pipe #(.RD_LATENCY(RD_LATENCY)) u_rd_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (rd_acc),
        .in_data   (rd_word),
        .out_valid (slave_readdatavalid),
        .out_data  (slave_readdata)
    );

    assign err = err_q;

endmodule

// File: tb/tb_board_mem_responder.sv
// Directed bench: main instance with one wait state, a second with zero wait states for back-to-back traffic.
module tb_board_mem_responder;

    logic clk = 1'b0;
    logic rst_n;

    logic        a_wait, a_read, a_write, a_valid, a_err, a_err_clr;
    logic [31:0] a_addr, a_wdata, a_rdata;
    logic        b_wait, b_read, b_write, b_valid, b_err, b_err_clr;
    logic [31:0] b_addr, b_wdata, b_rdata;

    int n_checks = 0;
    int n_pass   = 0;
    int a_pulses = 0;

    int          b_cmd   [16];
    logic [31:0] b_ad    [16];
    logic [31:0] b_wd    [16];
    int          b_pidx  [8];
    logic [31:0] b_pdat  [8];
    int          b_np;

    always #5 clk = ~clk;

    board_mem_responder dut_a (
        .clk(clk), .rst_n(rst_n),
        .slave_waitrequest(a_wait), .slave_address(a_addr), .slave_read(a_read),
        .slave_readdata(a_rdata), .slave_readdatavalid(a_valid),
        .slave_write(a_write), .slave_writedata(a_wdata),
        .err(a_err), .err_clr(a_err_clr)
    );

    board_mem_responder #(.NUM_BOARDS(8), .WAIT_STATES(0), .RD_LATENCY(2)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .slave_waitrequest(b_wait), .slave_address(b_addr), .slave_read(b_read),
        .slave_readdata(b_rdata), .slave_readdatavalid(b_valid),
        .slave_write(b_write), .slave_writedata(b_wdata),
        .err(b_err), .err_clr(b_err_clr)
    );

    always @(negedge clk) if (a_valid) a_pulses <= a_pulses + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Called just after driving a command on a negedge; returns the number of stalled cycles.
    task automatic accept_a(output int stalls);
        #1;
        stalls = 0;
        while (a_wait && stalls < 3000) begin
            @(negedge clk);
            #1;
            stalls++;
        end
        if (stalls >= 3000) check("accept_timeout", 32'(a_wait), 32'd0);
    endtask

    // Starts on the negedge following the acceptance edge; returns first pulse position.
    task automatic collect_a(output logic [31:0] data, output int lat);
        lat  = -1;
        data = 32'hDEAD_BEEF;
        for (int k = 1; k <= 10; k++) begin
            if (k > 1) @(negedge clk);
            if (a_valid && lat < 0) begin
                lat  = k;
                data = a_rdata;
            end
        end
    endtask

    task automatic rd_a(input logic [31:0] addr, output logic [31:0] data,
                        output int lat, output int stalls);
        @(negedge clk);
        a_read = 1'b1;
        a_addr = addr;
        accept_a(stalls);
        @(negedge clk);
        a_read = 1'b0;
        collect_a(data, lat);
    endtask

    task automatic wr_a(input logic [31:0] addr, input logic [31:0] wd, output int stalls);
        @(negedge clk);
        a_write = 1'b1;
        a_addr  = addr;
        a_wdata = wd;
        accept_a(stalls);
        @(negedge clk);
        a_write = 1'b0;
    endtask

    task automatic set_b(input int i, input int c, input logic [31:0] ad, input logic [31:0] wd);
        b_cmd[i] = c;
        b_ad[i]  = ad;
        b_wd[i]  = wd;
    endtask

    task automatic run_b();
        int n_wait_hi;
        n_wait_hi = 0;
        b_np = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (b_valid && b_np < 8) begin
                b_pidx[b_np] = i;
                b_pdat[b_np] = b_rdata;
                b_np++;
            end
            b_read  = (b_cmd[i] == 1);
            b_write = (b_cmd[i] == 2);
            b_addr  = b_ad[i];
            b_wdata = b_wd[i];
            #1;
            if ((b_read || b_write) && b_wait) n_wait_hi++;
        end
        @(negedge clk);
        b_read  = 1'b0;
        b_write = 1'b0;
        check("b_zero_wait", 32'(n_wait_hi), 32'd0);
    endtask

    initial begin
        logic [31:0] d;
        int lat, st, p0;

        rst_n = 1'b0;
        {a_read, a_write, a_err_clr} = '0;
        {b_read, b_write, b_err_clr} = '0;
        a_addr = '0; a_wdata = '0; b_addr = '0; b_wdata = '0;
        for (int i = 0; i < 16; i++) set_b(i, 0, 32'h0, 32'h0);

        // Reset values
        repeat (3) @(negedge clk);
        #1;
        check("rst_wait",  32'(a_wait),  32'd1);
        check("rst_valid", 32'(a_valid), 32'd0);
        check("rst_rdata", a_rdata,      32'h0);
        check("rst_err",   32'(a_err),   32'd0);

        // Test 1: read held from reset release through the CLEAR sweep
        @(negedge clk);
        rst_n  = 1'b1;
        a_read = 1'b1;
        a_addr = 32'h0;
        accept_a(st);
        check("clear_stalls", 32'(st), 32'd513);
        @(negedge clk);
        a_read = 1'b0;
        collect_a(d, lat);
        check("t1_latency", 32'(lat), 32'd2);
        check("t1_data",    d,        32'h0);

        // Test 2: sign-extended write/read-back
        wr_a(32'h104, 32'hFFFF_FFFB, st);
        check("t2_wr_stalls", 32'(st), 32'd1);
        rd_a(32'h104, d, lat, st);
        check("t2_rd_stalls", 32'(st), 32'd1);
        check("t2_neg5",      d,       32'hFFFF_FFFB);
        wr_a(32'h108, 32'h0000_0103, st);
        rd_a(32'h108, d, lat, st);
        check("t2_trunc",     d,       32'h0000_0003);
        check("t2_latency",   32'(lat), 32'd2);

        // Test 3: zero-wait instance, back-to-back reads and write ordering
        set_b(0, 2, 32'h0, 32'h22);
        set_b(1, 2, 32'h4, 32'h11);
        set_b(2, 2, 32'h8, 32'h80);
        set_b(4, 1, 32'h0, 32'h0);
        set_b(5, 1, 32'h4, 32'h0);
        set_b(6, 1, 32'h8, 32'h0);
        set_b(8, 1, 32'h4, 32'h0);
        set_b(9, 2, 32'h4, 32'h33);
        set_b(10, 1, 32'h4, 32'h0);
        run_b();
        check("b_pulses", 32'(b_np), 32'd5);
        check("b_p0_cyc", 32'(b_pidx[0]), 32'd6);
        check("b_p0_dat", b_pdat[0], 32'h22);
        check("b_p1_cyc", 32'(b_pidx[1]), 32'd7);
        check("b_p1_dat", b_pdat[1], 32'h11);
        check("b_p2_cyc", 32'(b_pidx[2]), 32'd8);
        check("b_p2_dat", b_pdat[2], 32'hFFFF_FF80);
        check("b_p3_old", b_pdat[3], 32'h11);
        check("b_p4_cyc", 32'(b_pidx[4]), 32'd12);
        check("b_p4_new", b_pdat[4], 32'h33);
        check("b_err",    32'(b_err), 32'd0);

        // Test 4: out-of-range access
        rd_a(32'h800, d, lat, st);
        check("t4_oor_data", d, 32'hFFFF_FFFF);
        check("t4_oor_lat",  32'(lat), 32'd2);
        check("t4_err_set",  32'(a_err), 32'd1);
        wr_a(32'h800, 32'h5A, st);
        rd_a(32'h800, d, lat, st);
        check("t4_oor_again", d, 32'hFFFF_FFFF);
        rd_a(32'h0, d, lat, st);
        check("t4_no_alias",  d, 32'h0);
        @(negedge clk);
        a_err_clr = 1'b1;
        @(negedge clk);
        a_err_clr = 1'b0;
        #1;
        check("t4_err_clr", 32'(a_err), 32'd0);

        // Test 5: read and write together behave as a write
        @(negedge clk);
        a_read  = 1'b1;
        a_write = 1'b1;
        a_addr  = 32'h10;
        a_wdata = 32'h7;
        accept_a(st);
        p0 = a_pulses;
        @(negedge clk);
        a_read  = 1'b0;
        a_write = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        check("t5_no_pulse", 32'(a_pulses), 32'(p0));
        check("t5_err",      32'(a_err),    32'd1);
        @(negedge clk);
        a_err_clr = 1'b1;
        @(negedge clk);
        a_err_clr = 1'b0;
        rd_a(32'h10, d, lat, st);
        check("t5_mem4", d, 32'h7);

        // Test 6: reset while a read is in flight
        wr_a(32'h20, 32'h42, st);
        rd_a(32'h20, d, lat, st);
        check("t6_prewrite", d, 32'h42);
        @(negedge clk);
        a_read = 1'b1;
        a_addr = 32'h20;
        accept_a(st);
        p0 = a_pulses;
        @(negedge clk);
        a_read = 1'b0;
        rst_n  = 1'b0;
        #1;
        check("t6_rst_valid", 32'(a_valid), 32'd0);
        check("t6_rst_wait",  32'(a_wait),  32'd1);
        repeat (3) @(negedge clk);
        #1;
        check("t6_dropped", 32'(a_pulses), 32'(p0));
        @(negedge clk);
        rst_n  = 1'b1;
        a_read = 1'b1;
        a_addr = 32'h20;
        accept_a(st);
        check("t6_reclear", 32'(st), 32'd513);
        @(negedge clk);
        a_read = 1'b0;
        collect_a(d, lat);
        #1;
        check("t6_cleared",  d, 32'h0);
        check("t6_one_more", 32'(a_pulses), 32'(p0 + 1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
